// File: rtl/mem_arbiter_pkg.sv
// rtl/mem_arbiter_pkg.sv - shared types and constants for the byte-wide RAM arbiter
// Purpose: arbiter state encodings, request owner, access sizes and common
// constants, plus the mem_size decode used at acceptance.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IdleSt  = 2'd0,
    ReadSt  = 2'd1,
    WriteSt = 2'd2,
    DoneSt  = 2'd3
  } arb_state_e;

  typedef enum logic {
    OwnIf  = 1'b0,
    OwnMem = 1'b1
  } arb_owner_e;

  localparam logic [2:0]  SizeB    = 3'd1;
  localparam logic [2:0]  SizeH    = 3'd2;
  localparam logic [2:0]  SizeW    = 3'd4;
  localparam logic        True     = 1'b1;
  localparam logic        False    = 1'b0;
  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // Sizes 0 and 3 are illegal and fall back to a full word.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd1:    size_bytes = SizeB;
      2'd2:    size_bytes = SizeH;
      default: size_bytes = SizeW;
    endcase
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - request, response and RAM-port bundle of the arbiter
// Purpose: groups the IF/MEM handshakes and the byte RAM port.
// Modports: slave  = arbiter side (requests and ram_din in, responses and RAM controls out)
//           master = environment side (CPU stages plus RAM model)
interface mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              jmp;
  logic              if_req;
  logic [31:0]       if_addr;
  logic [31:0]       if_data;
  logic              if_ok;
  logic              mem_req;
  logic              mem_we;
  logic [1:0]        mem_size;
  logic [31:0]       mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ok;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;

  modport slave (
    input  jmp, if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    output if_data, if_ok, mem_rdata, mem_ok, ram_a, ram_dout, ram_wr
  );

  modport master (
    output jmp, if_req, if_addr, mem_req, mem_we, mem_size, mem_addr, mem_wdata, ram_din,
    input  if_data, if_ok, mem_rdata, mem_ok, ram_a, ram_dout, ram_wr
  );
endinterface

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one byte-wide synchronous RAM between fetch and load/store
// Purpose: serialises 32-bit fetches and 1/2/4-byte loads/stores into byte
// accesses and returns little-endian words with a one-cycle done pulse.
// Ports: clk  - rising-edge clock
//        rst  - asynchronous active-low reset
//        bus  - mem_arbiter_if.slave (IF/MEM handshakes, RAM port)
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = 17
) (
  input logic          clk,
  input logic          rst,
  mem_arbiter_if.slave bus
);

  arb_state_e        r_state;
  arb_owner_e        r_owner;
  logic [2:0]        r_len;
  logic [2:0]        r_cnt;       // edges elapsed since the accept edge
  logic [ADDR_W-1:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_buf;
  logic [ADDR_W-1:0] r_ram_a;
  logic [7:0]        r_ram_dout;
  logic              r_ram_wr;
  logic [31:0]       r_if_data;
  logic              r_if_ok;
  logic [31:0]       r_mem_rdata;
  logic              r_mem_ok;

  logic [ADDR_W-1:0] w_addr_k;
  logic [7:0]        w_wbyte_k;
  logic [1:0]        w_cap_idx;
  logic [31:0]       w_buf_next;
  logic              w_last_rd;
  logic              w_unused;

  assign w_addr_k  = r_addr + ADDR_W'(r_cnt);
  assign w_wbyte_k = r_wdata[{r_cnt[1:0], 3'b000} +: 8];
  // ram_din lags its address by one cycle, so edge k captures byte k-2.
  assign w_cap_idx = 2'(r_cnt - 3'd2);
  assign w_last_rd = (r_cnt == r_len + 3'd1);
  assign w_unused  = ^{bus.if_addr[31:ADDR_W], bus.mem_addr[31:ADDR_W]};

  always_comb begin
    w_buf_next = r_buf;
    w_buf_next[{w_cap_idx, 3'b000} +: 8] = bus.ram_din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IdleSt;
      r_owner     <= OwnIf;
      r_len       <= 3'd0;
      r_cnt       <= 3'd0;
      r_addr      <= '0;
      r_wdata     <= ZeroWord;
      r_buf       <= ZeroWord;
      r_ram_a     <= '0;
      r_ram_dout  <= 8'h00;
      r_ram_wr    <= False;
      r_if_data   <= ZeroWord;
      r_if_ok     <= False;
      r_mem_rdata <= ZeroWord;
      r_mem_ok    <= False;
    end else begin
      case (r_state)
        IdleSt: begin
          r_cnt <= 3'd1;
          // Cleared per transaction so short loads come back zero-filled.
          r_buf <= ZeroWord;
          if (bus.mem_req) begin
            r_owner <= OwnMem;
            r_len   <= size_bytes(bus.mem_size);
            r_addr  <= bus.mem_addr[ADDR_W-1:0];
            r_wdata <= bus.mem_wdata;
            r_ram_a <= bus.mem_addr[ADDR_W-1:0];
            if (bus.mem_we) begin
              r_ram_wr   <= True;
              r_ram_dout <= bus.mem_wdata[7:0];
              r_state    <= WriteSt;
            end else begin
              r_ram_wr <= False;
              r_state  <= ReadSt;
            end
          end else if (bus.if_req && !bus.jmp) begin
            r_owner  <= OwnIf;
            r_len    <= SizeW;
            r_addr   <= bus.if_addr[ADDR_W-1:0];
            r_ram_a  <= bus.if_addr[ADDR_W-1:0];
            r_ram_wr <= False;
            r_state  <= ReadSt;
          end
        end

        ReadSt: begin
          r_cnt <= r_cnt + 3'd1;
          // A flush wins even on the completion edge; the stale fetch is dropped.
          if (r_owner == OwnIf && bus.jmp) begin
            r_state <= IdleSt;
          end else begin
            if (r_cnt < r_len) r_ram_a <= w_addr_k;
            if (r_cnt >= 3'd2) r_buf <= w_buf_next;
            if (w_last_rd) begin
              if (r_owner == OwnIf) begin
                r_if_data <= w_buf_next;
                r_if_ok   <= True;
              end else begin
                r_mem_rdata <= w_buf_next;
                r_mem_ok    <= True;
              end
              r_state <= DoneSt;
            end
          end
        end

        WriteSt: begin
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt < r_len) begin
            r_ram_a    <= w_addr_k;
            r_ram_dout <= w_wbyte_k;
          end else begin
            r_ram_wr <= False;
            r_mem_ok <= True;
            r_state  <= DoneSt;
          end
        end

        // One-cycle gap so a request still held high is not served twice.
        DoneSt: begin
          r_if_ok  <= False;
          r_mem_ok <= False;
          r_state  <= IdleSt;
        end

        default: r_state <= IdleSt;
      endcase
    end
  end

  assign bus.ram_a     = r_ram_a;
  assign bus.ram_dout  = r_ram_dout;
  assign bus.ram_wr    = r_ram_wr;
  assign bus.if_data   = r_if_data;
  assign bus.if_ok     = r_if_ok;
  assign bus.mem_rdata = r_mem_rdata;
  assign bus.mem_ok    = r_mem_ok;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter with a byte-array memory model
module tb_mem_arbiter;

  localparam int ADDR_W = 17;
  localparam int MEMSZ  = 1 << ADDR_W;
  localparam int AMASK  = MEMSZ - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

  logic [7:0] ram     [MEMSZ];
  logic [7:0] ref_mem [MEMSZ];
  int cyc    = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    cyc++;
    if (bus.ram_wr) begin
      ram[bus.ram_a] <= bus.ram_dout;
      wr_cnt++;
    end
    bus.ram_din <= ram[bus.ram_a];
  end

  typedef struct {
    bit          is_if;
    logic [31:0] exp_if;
    logic [31:0] exp_mem;
    int          ok_cyc;
  } exp_t;

  exp_t        sbq[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] last_if  = 32'h0;
  logic [31:0] last_mem = 32'h0;

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'd1) ? 1 : (s == 2'd2) ? 2 : 4;
  endfunction

  function automatic logic [31:0] model_read(input int a, input int n);
    logic [31:0] w;
    w = 32'h0;
    for (int k = 0; k < n; k++) w[8*k +: 8] = ref_mem[(a + k) & AMASK];
    return w;
  endfunction

  function automatic logic [31:0] raddr();
    logic [31:0] a;
    a = $urandom;
    a[16] = 1'b0;  // keep clear of the region used by the reset test
    return a;
  endfunction

  // Monitor: every completion pulse must match the head of the scoreboard.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst && (bus.if_ok || bus.mem_ok)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_ok actual if_ok=%0b mem_ok=%0b required=none", bus.if_ok, bus.mem_ok);
      end else begin
        e = sbq.pop_front();
        checkint("ok_source_if", int'(bus.if_ok), int'(e.is_if));
        checkint("ok_source_mem", int'(bus.mem_ok), int'(!e.is_if));
        check32("if_data", bus.if_data, e.exp_if);
        check32("mem_rdata", bus.mem_rdata, e.exp_mem);
        checkint("ok_cycle", cyc, e.ok_cyc);
      end
    end
  end

  task automatic wait_ok(input bit want_if);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      if (want_if ? bus.if_ok : bus.mem_ok) got = 1'b1;
    end
    if (!got) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout actual=no_ok required=ok", want_if ? "if" : "mem");
    end
  endtask

  task automatic op_mem(input bit we, input logic [1:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input bit with_if, input logic [31:0] faddr,
                        input bit hold_jmp);
    int   n, a, w0, acc, okc;
    exp_t e;
    n   = nbytes(sz);
    a   = int'(addr) & AMASK;
    w0  = wr_cnt;
    acc = cyc + 1;
    bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_size = sz;
    bus.mem_addr = addr; bus.mem_wdata = wd; bus.jmp = hold_jmp;
    if (with_if) begin bus.if_req = 1'b1; bus.if_addr = faddr; end
    if (we) begin
      for (int k = 0; k < n; k++) ref_mem[(a + k) & AMASK] = wd[8*k +: 8];
      okc = acc + n;
    end else begin
      last_mem = model_read(a, n);
      okc = acc + n + 1;
    end
    e.is_if = 1'b0; e.exp_if = last_if; e.exp_mem = last_mem; e.ok_cyc = okc;
    sbq.push_back(e);
    if (with_if) begin
      last_if = model_read(int'(faddr) & AMASK, 4);
      e.is_if = 1'b1; e.exp_if = last_if; e.ok_cyc = okc + 2 + 5;
      sbq.push_back(e);
    end
    wait_ok(1'b0);
    bus.mem_req = 1'b0; bus.jmp = 1'b0;
    if (we) checkint("store_wr_cycles", wr_cnt - w0, n);
    if (with_if) begin
      wait_ok(1'b1);
      bus.if_req = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic op_fetch(input logic [31:0] addr, input bit jmp_first);
    int   acc;
    exp_t e;
    bus.if_req = 1'b1; bus.if_addr = addr;
    if (jmp_first) begin
      bus.jmp = 1'b1;
      @(negedge clk);
      bus.jmp = 1'b0;
    end
    acc = cyc + 1;
    last_if = model_read(int'(addr) & AMASK, 4);
    e.is_if = 1'b1; e.exp_if = last_if; e.exp_mem = last_mem; e.ok_cyc = acc + 5;
    sbq.push_back(e);
    wait_ok(1'b1);
    bus.if_req = 1'b0;
    @(negedge clk);
  endtask

  // jmp is sampled at the k-th edge after the accept edge (k=5 is the completion edge).
  task automatic op_abort(input logic [31:0] addr, input int k);
    bus.if_req = 1'b1; bus.if_addr = addr;
    repeat (k) @(negedge clk);
    bus.jmp = 1'b1;
    @(negedge clk);
    bus.jmp = 1'b0; bus.if_req = 1'b0;
    checkint("abort_no_if_ok", int'(bus.if_ok), 0);
    check32("abort_if_data", bus.if_data, last_if);
  endtask

  task automatic op_reset_mid_store();
    logic [31:0] wd;
    wd = $urandom;
    bus.mem_req = 1'b1; bus.mem_we = 1'b1; bus.mem_size = 2'd0;
    bus.mem_addr = 32'h0001_8000; bus.mem_wdata = wd;
    @(negedge clk);
    @(negedge clk);
    checkint("wr_before_reset", int'(bus.ram_wr), 1);
    #2 rst = 1'b0;
    #1;
    checkint("reset_ram_wr", int'(bus.ram_wr), 0);
    checkint("reset_mem_ok", int'(bus.mem_ok), 0);
    checkint("reset_if_ok", int'(bus.if_ok), 0);
    check32("reset_if_data", bus.if_data, 32'h0);
    check32("reset_mem_rdata", bus.mem_rdata, 32'h0);
    bus.mem_req = 1'b0;
    ref_mem[32'h1_8000] = wd[7:0];
    last_if = 32'h0; last_mem = 32'h0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    bus.jmp = 1'b0; bus.if_req = 1'b0; bus.if_addr = 32'h0;
    bus.mem_req = 1'b0; bus.mem_we = 1'b0; bus.mem_size = 2'd0;
    bus.mem_addr = 32'h0; bus.mem_wdata = 32'h0;
    for (int i = 0; i < MEMSZ; i++) begin
      ram[i] = 8'($urandom);
      ref_mem[i] = ram[i];
    end
    ram[32'h100] = 8'h78; ram[32'h101] = 8'h56; ram[32'h102] = 8'h34; ram[32'h103] = 8'h12;
    ram[32'h20]  = 8'hCD; ram[32'h21]  = 8'hAB;
    for (int i = 0; i < 4; i++) ref_mem[32'h100 + i] = ram[32'h100 + i];
    for (int i = 0; i < 2; i++) ref_mem[32'h20 + i] = ram[32'h20 + i];

    repeat (2) @(negedge clk);
    check32("rst_if_data", bus.if_data, 32'h0);
    check32("rst_mem_rdata", bus.mem_rdata, 32'h0);
    checkint("rst_ok", int'({bus.if_ok, bus.mem_ok}), 0);
    checkint("rst_ram_wr", int'(bus.ram_wr), 0);
    checkint("rst_ram_a", int'(bus.ram_a), 0);
    rst = 1'b1;
    @(negedge clk);

    op_fetch(32'h0000_0100, 1'b0);
    check32("fetch_word", bus.if_data, 32'h1234_5678);
    op_mem(1'b0, 2'd2, 32'h0000_0020, 32'h0, 1'b1, 32'h0000_0100, 1'b0);
    check32("half_load", bus.mem_rdata, 32'h0000_ABCD);
    op_mem(1'b1, 2'd0, 32'h0000_0040, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0);
    op_mem(1'b0, 2'd0, 32'h0000_0040, 32'h0, 1'b0, 32'h0, 1'b0);
    check32("store_readback", bus.mem_rdata, 32'hDEAD_BEEF);
    op_abort(32'h0000_0200, 2);
    op_abort(32'h0000_0300, 5);
    op_fetch(32'h0000_0400, 1'b1);
    op_mem(1'b1, 2'd2, 32'h0000_0500, 32'hCAFE_F00D, 1'b0, 32'h0, 1'b1);
    op_reset_mid_store();
    op_fetch(32'h0000_0100, 1'b0);
    op_mem(1'b0, 2'd0, 32'h0001_FFFE, 32'h0, 1'b0, 32'h0, 1'b0);
    op_mem(1'b0, 2'd3, 32'hFFFF_FFFF, 32'h0, 1'b0, 32'h0, 1'b0);
    op_mem(1'b0, 2'd1, 32'h0000_0041, 32'h0, 1'b0, 32'h0, 1'b0);

    for (int it = 0; it < 60; it++) begin
      case ($urandom_range(0, 6))
        0: op_fetch(raddr(), 1'b0);
        1: op_fetch(raddr(), 1'b1);
        2: op_mem(1'b0, 2'($urandom), raddr(), 32'h0, 1'b0, 32'h0, 1'b0);
        3: op_mem(1'b1, 2'($urandom), raddr(), $urandom, 1'b0, 32'h0, 1'b0);
        4: op_mem(1'($urandom), 2'($urandom), raddr(), $urandom, 1'b1, raddr(), 1'b0);
        5: op_abort(raddr(), int'($urandom_range(1, 5)));
        default: op_mem(1'b1, 2'($urandom), raddr(), $urandom, 1'b0, 32'h0, 1'b1);
      endcase
    end

    repeat (4) @(negedge clk);
    checkint("scoreboard_empty", sbq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide synchronous RAM port.
- Shares it between instruction fetch (IF) and the MEM stage.
- Serialises each 32-bit fetch, and each 1/2/4-byte load or store, into byte accesses.
- Returns one assembled little-endian word with a one-cycle completion pulse; the IF stage uses this pulse to fill its instruction cache.

Parameters:
- ADDR_W, 17, width of the RAM byte address.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous active-low reset (0 = in reset)
- jmp  input  1  branch/jump flush; aborts an in-flight IF transaction
- if_req  input  1  fetch request, held high until if_ok or jmp
- if_addr  input  32  fetch byte address
- if_data  output  32  fetched word
- if_ok  output  1  one-cycle fetch-done pulse
- mem_req  input  1  load/store request, held high until mem_ok
- mem_we  input  1  1 = store, 0 = load
- mem_size  input  2  number of bytes: 1, 2 or 4 (0 and 3 illegal)
- mem_addr  input  32  load/store byte address
- mem_wdata  input  32  store data; bytes taken low first
- mem_rdata  output  32  load data, zero-filled above mem_size bytes
- mem_ok  output  1  one-cycle load/store-done pulse
- ram_a  output  ADDR_W  RAM byte address (addr[ADDR_W-1:0])
- ram_dout  output  8  RAM write byte
- ram_wr  output  1  RAM write strobe
- ram_din  input  8  RAM read byte, valid one cycle after its address

Behaviour:
- Reset (rst=0), asynchronous: all outputs 0, state IDLE, byte counter 0, latched request cleared. ram_wr drops immediately, even mid-store.
- All outputs are registered.
- States: IDLE, READ, WRITE, DONE.
- Acceptance in IDLE, at an edge:
  - MEM has priority: if mem_req=1, latch mem_we/size/addr/wdata, owner=MEM, go to READ or WRITE.
  - Else if if_req=1 and jmp=0, latch if_addr, size=4, owner=IF, go to READ.
- Accept edge E0 drives ram_a=addr, ram_wr=0 (READ) or ram_wr=1, ram_dout=byte0 (WRITE).
- READ of N bytes:
  - Edges E1..E(N-1) drive ram_a=addr+k.
  - Byte k is captured from ram_din at E(k+2) into bits [8k+7:8k].
  - At E(N+1): the owner's data output is updated and its ok is set; go to DONE.
  - 4-byte fetch latency: ok visible 5 cycles after accept (1-byte load: 2 cycles).
- WRITE of N bytes:
  - Edges E1..E(N-1) drive ram_a=addr+k, ram_dout=byte k, ram_wr=1.
  - At E(N): ram_wr=0, mem_ok=1; go to DONE. A word store has mem_ok visible 4 cycles after accept.
- DONE: lasts exactly one cycle with ok high. No acceptance during it, so a still-high req is not double-served. Next edge: ok=0, go to IDLE.
- if_data and mem_rdata hold their last value between transactions.
- Address arithmetic: addr+k wraps modulo 2^ADDR_W; no alignment is required.
- jmp:
  - Sampled high at any edge while owner=IF in READ (including the would-be completion edge): go to IDLE, no if_ok, if_data unchanged.
  - Ignored while owner=MEM, so stores always complete.
  - In IDLE, jmp=1 blocks IF acceptance for that edge only; MEM may still be accepted.
- Requests that arrive while busy wait; nothing is queued inside the block.
- Illegal mem_size is treated as 4.

Decomposition:
- defines.v gains:
  - arbiter state encodings: IdleSt, ReadSt, WriteSt, DoneSt
  - size constants: SizeB=1, SizeH=2, SizeW=4
  - RamAddrBus: ADDR_W-1:0
  - ByteBus: 7:0
- Existing True/False/ZeroWord are reused.
- Single flat module. No sub-module: the byte assembler is too small to justify one.

Test Plan:
- Fetch: RAM[0x100..0x103]=78,56,34,12; if_req, if_addr=0x100 -> ram_a sequence 0x100..0x103, if_ok one cycle at accept+5, if_data=0x12345678, next accept no earlier than 2 cycles after if_ok.
- Priority: mem_req load, size 2, addr 0x20 (RAM=CD,AB) and if_req high in the same cycle -> MEM served first, mem_rdata=0x0000ABCD at accept+3; fetch accepted after DONE.
- Store: mem_we=1, size 4, addr 0x40, wdata=0xDEADBEEF -> ram_wr=1 for exactly 4 cycles with bytes EF,BE,AD,DE at 0x40..0x43; mem_ok at accept+4; readback word returns 0xDEADBEEF.
- Jump abort: fetch accepted, jmp pulse at accept+2 -> IDLE next edge, no if_ok, if_data unchanged; jmp at the completion edge also yields no if_ok.
- Reset mid-store: rst=0 while ram_wr=1 -> ram_wr, mem_ok, if_ok = 0 immediately without a clock edge; after release, a fresh fetch completes normally.
- Wrap and odd address: load, size 4, addr 2^ADDR_W-2 -> ram_a sequence 1FFFE,1FFFF,0,1 (ADDR_W=17); mem_rdata assembled little-endian.
